rf_bank_req_queue: RTL and testbench

- Parametrised per-bank register-file request queue.
- Sits between the operand-collector/RAU allocation stage and one RF bank.
- Each cycle it accepts zero, one or two source-operand read requests, arbitrates the single RF port between CDB writeback and queued reads, and returns a read-response tag aligned to RF read latency.
- Successor to the fixed 8-deep queue: adds configurable depth and widths, an all-or-nothing enqueue handshake, a write-starvation guard, a latency-matched response pipeline, and occupancy outputs.

---
 rtl/rf_bank_req_queue.sv | 148 ++++++++++++++
 tb/tb_rf_bank_req_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_bank_req_queue.sv
// Per-bank register-file request queue: enqueues up to two operand reads per cycle,
// arbitrates the single RF port between CDB writeback and reads, and returns response tags.
module rf_bank_req_queue #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ROW_W      = 3,
  parameter int unsigned OCID_W     = 3,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic                     src1_valid,
  input  logic                     src2_valid,
  input  logic [ROW_W-1:0]         src1_row,
  input  logic [ROW_W-1:0]         src2_row,
  input  logic [OCID_W-1:0]        src1_ocid,
  input  logic [OCID_W-1:0]        src2_ocid,
  input  logic                     src_same,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ROW_W-1:0]         wr_row,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [ROW_W-1:0]         rf_addr,
  output logic                     rf_wr,
  output logic                     rf_rd,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     rsp_valid,
  output logic [OCID_W-1:0]        rsp_ocid,
  output logic                     rsp_same,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [SW-1:0] STARVE_P = SW'(STARVE_MAX);

  typedef struct packed {
    logic              same;
    logic [OCID_W-1:0] ocid;
    logic [ROW_W-1:0]  row;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     wp, rp, wp_nxt1, free_slots;
  logic [SW-1:0]     starve_cnt;
  logic [1:0]        n;
  entry_t            ent0, ent1, head;
  logic              enq_fire;

  logic              pipe_v    [RD_LAT];
  logic [OCID_W-1:0] pipe_ocid [RD_LAT];
  logic              pipe_same [RD_LAT];

  assign count      = wp - rp;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_P);
  assign free_slots = DEPTH_P - count;
  assign wp_nxt1    = wp + PW'(1);
  assign head       = mem[rp[AW-1:0]];

  // Bundle decode: src_same collapses both sources into one src1 entry tagged same=1.
  always_comb begin
    n    = 2'd0;
    ent0 = '{same: 1'b0, ocid: src1_ocid, row: src1_row};
    ent1 = '{same: 1'b0, ocid: src2_ocid, row: src2_row};
    if (src1_valid && src2_valid) begin
      if (src_same) begin
        n         = 2'd1;
        ent0.same = 1'b1;
      end else begin
        n = 2'd2;
      end
    end else if (src1_valid) begin
      n = 2'd1;
    end else if (src2_valid) begin
      n    = 2'd1;
      ent0 = ent1;
    end
  end

  assign enq_ready = (free_slots >= PW'(n));
  assign enq_fire  = enq_valid && enq_ready && (n != 2'd0);

  assign wr_ready = !((starve_cnt == STARVE_P) && !empty);
  assign rf_wr    = wr_valid && wr_ready;
  assign rf_rd    = !rf_wr && !empty;
  assign rf_wdata = wr_data;

  always_comb begin
    rf_addr = '0;
    if (rf_wr)      rf_addr = wr_row;
    else if (rf_rd) rf_addr = head.row;
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wp[AW-1:0]] <= ent0;
      if (n == 2'd2) mem[wp_nxt1[AW-1:0]] <= ent1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp         <= '0;
      rp         <= '0;
      starve_cnt <= '0;
    end else begin
      if (enq_fire) wp <= wp + PW'(n);
      if (rf_rd)    rp <= rp + PW'(1);
      if (empty || rf_rd)
        starve_cnt <= '0;
      else if (rf_wr && (starve_cnt != STARVE_P))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Tags are zeroed on idle cycles so rsp_ocid/rsp_same read 0 whenever rsp_valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_ocid[i] <= '0;
        pipe_same[i] <= 1'b0;
      end
    end else begin
      pipe_v[0]    <= rf_rd;
      pipe_ocid[0] <= rf_rd ? head.ocid : '0;
      pipe_same[0] <= rf_rd && head.same;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_ocid[i] <= pipe_ocid[i-1];
        pipe_same[i] <= pipe_same[i-1];
      end
    end
  end

  assign rsp_valid = pipe_v[RD_LAT-1];
  assign rsp_ocid  = pipe_ocid[RD_LAT-1];
  assign rsp_same  = pipe_same[RD_LAT-1];

endmodule

// File: tb/tb_rf_bank_req_queue.sv
// Directed self-checking bench for rf_bank_req_queue with default parameters
// (DEPTH=8, ROW_W=3, OCID_W=3, DATA_W=256, RD_LAT=1, STARVE_MAX=4).
module tb_rf_bank_req_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         enq_valid, enq_ready;
  logic         src1_valid, src2_valid, src_same;
  logic [2:0]   src1_row, src2_row, src1_ocid, src2_ocid;
  logic         wr_valid, wr_ready;
  logic [2:0]   wr_row;
  logic [255:0] wr_data;
  logic [2:0]   rf_addr;
  logic         rf_wr, rf_rd;
  logic [255:0] rf_wdata;
  logic         rsp_valid, rsp_same;
  logic [2:0]   rsp_ocid;
  logic [3:0]   count;
  logic         full, empty;

  int vecs = 0;
  int errs = 0;

  rf_bank_req_queue #(
    .DEPTH(8), .ROW_W(3), .OCID_W(3), .DATA_W(256), .RD_LAT(1), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .src1_valid(src1_valid), .src2_valid(src2_valid),
    .src1_row(src1_row), .src2_row(src2_row),
    .src1_ocid(src1_ocid), .src2_ocid(src2_ocid),
    .src_same(src_same),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data),
    .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rsp_valid(rsp_valid), .rsp_ocid(rsp_ocid), .rsp_same(rsp_same),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s1v, input logic [2:0] r1, input logic [2:0] o1,
                       input logic s2v, input logic [2:0] r2, input logic [2:0] o2, input logic same);
    enq_valid = v; src1_valid = s1v; src1_row = r1; src1_ocid = o1;
    src2_valid = s2v; src2_row = r2; src2_ocid = o2; src_same = same;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0; idle; wr_valid = 1'b1; wr_row = 3'd3; wr_data = '0;
    #7;
    vecs++; if (count !== 4'd0)     begin errs++; $display("FAIL rst_count got %0d want 0", count); end
    vecs++; if (empty !== 1'b1)     begin errs++; $display("FAIL rst_empty got %b want 1", empty); end
    vecs++; if (full !== 1'b0)      begin errs++; $display("FAIL rst_full got %b want 0", full); end
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    vecs++; if (rf_rd !== 1'b0)     begin errs++; $display("FAIL rst_rf_rd got %b want 0", rf_rd); end
    vecs++; if (enq_ready !== 1'b1) begin errs++; $display("FAIL rst_enq_ready got %b want 1", enq_ready); end
    vecs++; if (rf_wr !== 1'b1)     begin errs++; $display("FAIL rst_rf_wr got %b want 1", rf_wr); end
    wr_valid = 1'b0;
    #1;
    vecs++; if (rf_wr !== 1'b0)     begin errs++; $display("FAIL rst_rf_wr_low got %b want 0", rf_wr); end
    @(negedge clk) rst = 1'b1;
    tick;
  endtask

  task automatic test_two_src;
    drive(1'b1, 1'b1, 3'd5, 3'd2, 1'b1, 3'd3, 3'd6, 1'b0);
    #1;
    vecs++; if (enq_ready !== 1'b1) begin errs++; $display("FAIL two_enq_ready got %b want 1", enq_ready); end
    tick; idle; #1;
    vecs++; if (count !== 4'd2)     begin errs++; $display("FAIL two_count got %0d want 2", count); end
    vecs++; if (rf_rd !== 1'b1)     begin errs++; $display("FAIL two_rd0 got %b want 1", rf_rd); end
    vecs++; if (rf_addr !== 3'd5)   begin errs++; $display("FAIL two_addr0 got %0d want 5", rf_addr); end
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL two_rsp_early got %b want 0", rsp_valid); end
    tick;
    vecs++; if (count !== 4'd1)     begin errs++; $display("FAIL two_count1 got %0d want 1", count); end
    vecs++; if (rf_addr !== 3'd3)   begin errs++; $display("FAIL two_addr1 got %0d want 3", rf_addr); end
    vecs++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL two_rsp0_v got %b want 1", rsp_valid); end
    vecs++; if (rsp_ocid !== 3'd2)  begin errs++; $display("FAIL two_rsp0_ocid got %0d want 2", rsp_ocid); end
    tick;
    vecs++; if (empty !== 1'b1)     begin errs++; $display("FAIL two_empty got %b want 1", empty); end
    vecs++; if (rf_rd !== 1'b0)     begin errs++; $display("FAIL two_rd_idle got %b want 0", rf_rd); end
    vecs++; if (rf_addr !== 3'd0)   begin errs++; $display("FAIL two_addr_idle got %0d want 0", rf_addr); end
    vecs++; if (rsp_ocid !== 3'd6)  begin errs++; $display("FAIL two_rsp1_ocid got %0d want 6", rsp_ocid); end
    vecs++; if (rsp_same !== 1'b0)  begin errs++; $display("FAIL two_rsp1_same got %b want 0", rsp_same); end
    tick;
    vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL two_rsp_done got %b want 0", rsp_valid); end
    vecs++; if (rsp_ocid !== 3'd0)  begin errs++; $display("FAIL two_rsp_ocid_zero got %0d want 0", rsp_ocid); end
  endtask

  task automatic test_same;
    drive(1'b1, 1'b1, 3'd4, 3'd1, 1'b1, 3'd4, 3'd1, 1'b1);
    #1;
    tick; idle; #1;
    vecs++; if (count !== 4'd1)     begin errs++; $display("FAIL same_count got %0d want 1", count); end
    vecs++; if (rf_addr !== 3'd4)   begin errs++; $display("FAIL same_addr got %0d want 4", rf_addr); end
    tick;
    vecs++; if (empty !== 1'b1)     begin errs++; $display("FAIL same_empty got %b want 1", empty); end
    vecs++; if (rsp_valid !== 1'b1) begin errs++; $display("FAIL same_rsp_v got %b want 1", rsp_valid); end
    vecs++; if (rsp_ocid !== 3'd1)  begin errs++; $display("FAIL same_rsp_ocid got %0d want 1", rsp_ocid); end
    vecs++; if (rsp_same !== 1'b1)  begin errs++; $display("FAIL same_rsp_same got %b want 1", rsp_same); end
    tick;
    vecs++; if (rsp_same !== 1'b0)  begin errs++; $display("FAIL same_rsp_same_clr got %b want 0", rsp_same); end
  endtask

  // Writes are held high so reads stay blocked while filling; ocid = row ^ 3 throughout.
  task automatic test_full;
    int exp_row [8];
    exp_row = '{2, 3, 4, 5, 6, 7, 2, 6};
    wr_valid = 1'b1; wr_row = 3'd7; wr_data = {8{32'hA5A5_0F0F}};
    drive(1'b1, 1'b1, 3'd1, 3'd2, 1'b1, 3'd2, 3'd1, 1'b0); #1;
    vecs++; if (rf_wr !== 1'b1)     begin errs++; $display("FAIL full_wr_a got %b want 1", rf_wr); end
    tick;
    drive(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 3'd4, 3'd7, 1'b0); #1;
    vecs++; if (count !== 4'd2)     begin errs++; $display("FAIL full_count_b got %0d want 2", count); end
    tick;
    drive(1'b1, 1'b1, 3'd5, 3'd6, 1'b1, 3'd6, 3'd5, 1'b0); #1;
    vecs++; if (count !== 4'd4)     begin errs++; $display("FAIL full_count_c got %0d want 4", count); end
    tick;
    drive(1'b1, 1'b1, 3'd7, 3'd4, 1'b0, 3'd0, 3'd0, 1'b0); #1;
    vecs++; if (count !== 4'd6)     begin errs++; $display("FAIL full_count_d got %0d want 6", count); end
    tick;
    drive(1'b1, 1'b1, 3'd0, 3'd3, 1'b1, 3'd0, 3'd3, 1'b0); #1;
    vecs++; if (count !== 4'd7)     begin errs++; $display("FAIL full_count_e got %0d want 7", count); end
    vecs++; if (enq_ready !== 1'b0) begin errs++; $display("FAIL full_refuse2 got %b want 0", enq_ready); end
    vecs++; if (rf_wr !== 1'b1)     begin errs++; $display("FAIL full_wr_e got %b want 1", rf_wr); end
    tick;
    drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 3'd1, 1'b0); #1;
    vecs++; if (count !== 4'd7)     begin errs++; $display("FAIL full_count_f got %0d want 7", count); end
    vecs++; if (enq_ready !== 1'b1) begin errs++; $display("FAIL full_accept1 got %b want 1", enq_ready); end
    vecs++; if (wr_ready !== 1'b0)  begin errs++; $display("FAIL full_starve_f got %b want 0", wr_ready); end
    vecs++; if (rf_addr !== 3'd1)   begin errs++; $display("FAIL full_addr_f got %0d want 1", rf_addr); end
    tick;
    drive(1'b1, 1'b1, 3'd6, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0); #1;
    vecs++; if (count !== 4'd7)     begin errs++; $display("FAIL full_count_g got %0d want 7", count); end
    vecs++; if (rf_wr !== 1'b1)     begin errs++; $display("FAIL full_wr_g got %b want 1", rf_wr); end
    tick;
    drive(1'b1, 1'b1, 3'd0, 3'd3, 1'b0, 3'd0, 3'd0, 1'b0); #1;
    vecs++; if (count !== 4'd8)     begin errs++; $display("FAIL full_count_h got %0d want 8", count); end
    vecs++; if (full !== 1'b1)      begin errs++; $display("FAIL full_flag got %b want 1", full); end
    vecs++; if (enq_ready !== 1'b0) begin errs++; $display("FAIL full_refuse1 got %b want 0", enq_ready); end
    idle; wr_valid = 1'b0; #1;
    for (int k = 0; k < 8; k++) begin
      vecs++; if (rf_rd !== 1'b1 || rf_addr !== 3'(exp_row[k]))
        begin errs++; $display("FAIL drain_addr[%0d] got rd=%b addr=%0d want rd=1 addr=%0d", k, rf_rd, rf_addr, exp_row[k]); end
      if (k > 0) begin
        vecs++; if (rsp_ocid !== (3'(exp_row[k-1]) ^ 3'd3))
          begin errs++; $display("FAIL drain_ocid[%0d] got %0d want %0d", k, rsp_ocid, 3'(exp_row[k-1]) ^ 3'd3); end
      end
      tick;
    end
    vecs++; if (empty !== 1'b1)     begin errs++; $display("FAIL drain_empty got %b want 1", empty); end
    vecs++; if (rsp_ocid !== 3'd5)  begin errs++; $display("FAIL drain_last_ocid got %0d want 5", rsp_ocid); end
  endtask

  task automatic test_starve;
    logic [255:0] pat;
    pat = {8{32'h1234_5678}};
    wr_valid = 1'b1; wr_row = 3'd2; wr_data = pat;
    drive(1'b1, 1'b1, 3'd5, 3'd3, 1'b1, 3'd1, 3'd4, 1'b0); #1;
    vecs++; if (rf_wr !== 1'b1)     begin errs++; $display("FAIL starve_wr_a got %b want 1", rf_wr); end
    tick; idle; #1;
    for (int c = 0; c < 4; c++) begin
      vecs++; if (wr_ready !== 1'b1 || rf_wr !== 1'b1 || rf_rd !== 1'b0 || rf_addr !== 3'd2)
        begin errs++; $display("FAIL starve_wr[%0d] got rdy=%b wr=%b rd=%b addr=%0d want 1 1 0 2", c, wr_ready, rf_wr, rf_rd, rf_addr); end
      vecs++; if (rf_wdata !== pat) begin errs++; $display("FAIL starve_wdata[%0d] got %h want %h", c, rf_wdata, pat); end
      tick;
    end
    vecs++; if (wr_ready !== 1'b0 || rf_wr !== 1'b0 || rf_rd !== 1'b1 || rf_addr !== 3'd5)
      begin errs++; $display("FAIL starve_read got rdy=%b wr=%b rd=%b addr=%0d want 0 0 1 5", wr_ready, rf_wr, rf_rd, rf_addr); end
    tick;
    vecs++; if (wr_ready !== 1'b1 || rf_wr !== 1'b1)
      begin errs++; $display("FAIL starve_resume got rdy=%b wr=%b want 1 1", wr_ready, rf_wr); end
    vecs++; if (rsp_valid !== 1'b1 || rsp_ocid !== 3'd3)
      begin errs++; $display("FAIL starve_rsp got v=%b ocid=%0d want 1 3", rsp_valid, rsp_ocid); end
    wr_valid = 1'b0; #1;
    vecs++; if (rf_rd !== 1'b1 || rf_addr !== 3'd1)
      begin errs++; $display("FAIL starve_rd2 got rd=%b addr=%0d want 1 1", rf_rd, rf_addr); end
    tick;
    vecs++; if (rsp_ocid !== 3'd4 || empty !== 1'b1)
      begin errs++; $display("FAIL starve_rsp2 got ocid=%0d empty=%b want 4 1", rsp_ocid, empty); end
  endtask

  task automatic test_wr_empty;
    logic [255:0] pat;
    pat = {4{64'hFEED_0001_C0DE_BEEF}};
    wr_valid = 1'b1; wr_row = 3'd6; wr_data = pat;
    drive(1'b1, 1'b1, 3'd2, 3'd7, 1'b0, 3'd0, 3'd0, 1'b0); #1;
    vecs++; if (rf_wr !== 1'b1 || wr_ready !== 1'b1 || rf_rd !== 1'b0)
      begin errs++; $display("FAIL wre_grant got wr=%b rdy=%b rd=%b want 1 1 0", rf_wr, wr_ready, rf_rd); end
    vecs++; if (rf_addr !== 3'd6)   begin errs++; $display("FAIL wre_addr got %0d want 6", rf_addr); end
    vecs++; if (rf_wdata !== pat)   begin errs++; $display("FAIL wre_wdata got %h want %h", rf_wdata, pat); end
    tick; idle; wr_valid = 1'b0; #1;
    vecs++; if (rf_rd !== 1'b1 || rf_addr !== 3'd2)
      begin errs++; $display("FAIL wre_read got rd=%b addr=%0d want 1 2", rf_rd, rf_addr); end
    tick;
    vecs++; if (rsp_valid !== 1'b1 || rsp_ocid !== 3'd7)
      begin errs++; $display("FAIL wre_rsp got v=%b ocid=%0d want 1 7", rsp_valid, rsp_ocid); end
  endtask

  task automatic test_reset_mid;
    wr_valid = 1'b0;
    drive(1'b1, 1'b1, 3'd1, 3'd1, 1'b1, 3'd2, 3'd2, 1'b0); #1;
    tick;
    drive(1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 3'd4, 3'd4, 1'b0); #1;
    tick; idle; #1;
    vecs++; if (count !== 4'd3 || rsp_valid !== 1'b1)
      begin errs++; $display("FAIL mid_pre got count=%0d rsp=%b want 3 1", count, rsp_valid); end
    #1 rst = 1'b0;
    #1;
    vecs++; if (count !== 4'd0 || empty !== 1'b1)
      begin errs++; $display("FAIL mid_count got count=%0d empty=%b want 0 1", count, empty); end
    vecs++; if (rsp_valid !== 1'b0 || rf_rd !== 1'b0)
      begin errs++; $display("FAIL mid_rsp got rsp=%b rd=%b want 0 0", rsp_valid, rf_rd); end
    @(negedge clk); @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      vecs++; if (rsp_valid !== 1'b0 || count !== 4'd0)
        begin errs++; $display("FAIL mid_post[%0d] got rsp=%b count=%0d want 0 0", c, rsp_valid, count); end
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 1'b1, 3'(i % 8), 3'((i + 1) % 8), 1'b0, 3'd0, 3'd0, 1'b0); #1;
      if (i == 0) begin
        vecs++; if (rf_rd !== 1'b0) begin errs++; $display("FAIL wrap_first_rd got %b want 0", rf_rd); end
      end else begin
        vecs++; if (rf_rd !== 1'b1 || rf_addr !== 3'((i - 1) % 8) || count !== 4'd1)
          begin errs++; $display("FAIL wrap_rd[%0d] got rd=%b addr=%0d count=%0d want 1 %0d 1", i, rf_rd, rf_addr, count, (i - 1) % 8); end
      end
      if (i >= 2) begin
        vecs++; if (rsp_valid !== 1'b1 || rsp_ocid !== 3'((i - 1) % 8))
          begin errs++; $display("FAIL wrap_rsp[%0d] got v=%b ocid=%0d want 1 %0d", i, rsp_valid, rsp_ocid, (i - 1) % 8); end
      end
      tick;
    end
    idle; #1;
    vecs++; if (rf_addr !== 3'd2 || count !== 4'd1)
      begin errs++; $display("FAIL wrap_tail got addr=%0d count=%0d want 2 1", rf_addr, count); end
    tick;
    vecs++; if (rsp_ocid !== 3'd3 || empty !== 1'b1)
      begin errs++; $display("FAIL wrap_end got ocid=%0d empty=%b want 3 1", rsp_ocid, empty); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle; wr_valid = 1'b0; wr_row = '0; wr_data = '0;
    test_reset;
    test_two_src;
    test_same;
    test_full;
    test_starve;
    test_wr_empty;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
